// File: rtl/run_controller.sv
// run_controller: fetch/execute sequencer between the 8-bit core and its ROM.
// Define BREAKPOINT_EN to add a PC breakpoint with halt and single-pass resume.
module run_controller #(
   parameter int PROG_LEN = 21,
   parameter int CNT_W    = 16
) (
   input  logic             origclk,
   input  logic             reset,
   input  logic             run,
   input  logic             step,
   input  logic             halt_req,
   input  logic [7:0]       cpu_pc,
   output logic [7:0]       rom_addr,
   input  logic [7:0]       rom_data,
   output logic [7:0]       cpu_instruction,
   output logic             cpu_en,
   output logic [1:0]       state,
   output logic             done,
   output logic             bp_hit,
   input  logic [7:0]       bp_addr,
   input  logic             bp_valid,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_FETCH = 2'b01,
      S_EXEC  = 2'b10,
      S_HALT  = 2'b11
   } state_t;

   state_t           r_state;
   logic             r_step_q;
   logic             r_single;
   logic             r_skip;
   logic             r_cpu_en;
   logic             r_done;
   logic             r_bp_hit;
   logic [7:0]       r_instr;
   logic [CNT_W-1:0] r_retired;

   logic             w_step_edge;
   logic             w_end;
   logic             w_bp;

   assign rom_addr    = cpu_pc;
   assign w_step_edge = step & ~r_step_q;
   assign w_end       = ({24'd0, cpu_pc} >= 32'(PROG_LEN));

`ifdef BREAKPOINT_EN
   assign w_bp = bp_valid & (cpu_pc == bp_addr) & ~r_skip;
`else
   logic w_unused;
   assign w_unused = ^{bp_addr, bp_valid, r_skip};
   assign w_bp     = 1'b0;
`endif

   always_ff @(posedge origclk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_step_q  <= 1'b0;
         r_single  <= 1'b0;
         r_skip    <= 1'b0;
         r_cpu_en  <= 1'b0;
         r_done    <= 1'b0;
         r_bp_hit  <= 1'b0;
         r_instr   <= 8'h00;
         r_retired <= '0;
      end else begin
         r_step_q <= step;
         r_cpu_en <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (halt_req) begin
                  r_state <= S_HALT;
               end else if (run | w_step_edge) begin
                  r_state  <= S_FETCH;
                  r_single <= ~run;
               end
            end
            S_FETCH: begin
               if (w_end) begin
                  r_state <= S_HALT;
                  r_done  <= 1'b1;
               end else if (w_bp) begin
                  r_state  <= S_HALT;
                  r_bp_hit <= 1'b1;
               end else begin
                  r_instr  <= rom_data;
                  r_cpu_en <= 1'b1;
                  r_state  <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (r_retired != '1) begin
                  r_retired <= r_retired + 1'b1;
               end
               r_skip <= 1'b0;
               if (halt_req) begin
                  r_state <= S_HALT;
               end else if (r_single) begin
                  r_state <= S_IDLE;
               end else if (run) begin
                  r_state <= S_FETCH;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_HALT: begin
               // end of program is terminal; only reset leaves it
               if (!r_done && !halt_req && !run) begin
                  r_state  <= S_IDLE;
                  r_skip   <= r_bp_hit;
                  r_bp_hit <= 1'b0;
               end
            end
         endcase
      end
   end

   assign cpu_instruction = r_instr;
   assign cpu_en          = r_cpu_en;
   assign state           = r_state;
   assign done            = r_done;
   assign bp_hit          = r_bp_hit;
   assign retired         = r_retired;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: plays the core and ROM, checks against a cycle model.
// Breakpoint scenario runs only when BREAKPOINT_EN is defined.
module tb_run_controller;

   localparam int PROG_LEN = 21;
   localparam int CNT_W    = 16;
   localparam int RET_MAX  = (1 << CNT_W) - 1;
`ifdef BREAKPOINT_EN
   localparam bit BP_ON = 1'b1;
`else
   localparam bit BP_ON = 1'b0;
`endif

   logic             clk      = 1'b0;
   logic             rst_n    = 1'b1;
   logic             run      = 1'b0;
   logic             step     = 1'b0;
   logic             halt_req = 1'b0;
   logic             bp_valid = 1'b0;
   logic [7:0]       bp_addr  = 8'h00;
   logic [7:0]       cpu_pc;
   logic [7:0]       rom_addr;
   logic [7:0]       rom_data;
   logic [7:0]       cpu_instruction;
   logic             cpu_en;
   logic [1:0]       state;
   logic             done;
   logic             bp_hit;
   logic [CNT_W-1:0] retired;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   run_controller #(.PROG_LEN(PROG_LEN), .CNT_W(CNT_W)) dut (
      .origclk         (clk),
      .reset           (rst_n),
      .run             (run),
      .step            (step),
      .halt_req        (halt_req),
      .cpu_pc          (cpu_pc),
      .rom_addr        (rom_addr),
      .rom_data        (rom_data),
      .cpu_instruction (cpu_instruction),
      .cpu_en          (cpu_en),
      .state           (state),
      .done            (done),
      .bp_hit          (bp_hit),
      .bp_addr         (bp_addr),
      .bp_valid        (bp_valid),
      .retired         (retired)
   );

   function automatic logic [7:0] rom_fn(input logic [7:0] a);
      return (a * 8'd37 + 8'd11) ^ 8'h5A;
   endfunction

   assign rom_data = rom_fn(rom_addr);

   // the core: PC advances on every committed instruction
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cpu_pc <= 8'h00;
      else if (cpu_en) cpu_pc <= cpu_pc + 8'd1;
   end

   task automatic check(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // behavioural model: phase 0 idle, 1 fetch, 2 exec, 3 halt
   int         m_phase;
   logic [7:0] m_instr;
   logic       m_done, m_bp, m_single, m_skip, m_stepq;
   int         m_ret;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase  <= 0;
         m_instr  <= 8'h00;
         m_done   <= 1'b0;
         m_bp     <= 1'b0;
         m_single <= 1'b0;
         m_skip   <= 1'b0;
         m_stepq  <= 1'b0;
         m_ret    <= 0;
      end else begin
         m_stepq <= step;
         case (m_phase)
            0: begin
               if (halt_req) m_phase <= 3;
               else if (run || (step && !m_stepq)) begin
                  m_phase  <= 1;
                  m_single <= !run;
               end
            end
            1: begin
               if (int'(cpu_pc) >= PROG_LEN) begin
                  m_phase <= 3;
                  m_done  <= 1'b1;
               end else if (BP_ON && bp_valid && cpu_pc == bp_addr && !m_skip) begin
                  m_phase <= 3;
                  m_bp    <= 1'b1;
               end else begin
                  m_instr <= rom_fn(cpu_pc);
                  m_phase <= 2;
               end
            end
            2: begin
               m_ret   <= (m_ret >= RET_MAX) ? RET_MAX : m_ret + 1;
               m_skip  <= 1'b0;
               m_phase <= halt_req ? 3 : ((!m_single && run) ? 1 : 0);
            end
            3: begin
               if (!m_done && !halt_req && !run) begin
                  m_phase <= 0;
                  m_skip  <= m_bp;
                  m_bp    <= 1'b0;
               end
            end
            default: m_phase <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      check("state", 32'(state), m_phase);
      check("cpu_en", 32'(cpu_en), 32'(m_phase == 2));
      check("instr", 32'(cpu_instruction), 32'(m_instr));
      check("done", 32'(done), 32'(m_done));
      check("bp_hit", 32'(bp_hit), 32'(m_bp));
      check("retired", 32'(retired), m_ret);
      check("rom_addr", 32'(rom_addr), 32'(cpu_pc));
   end

   task automatic do_reset();
      run      = 1'b0;
      step     = 1'b0;
      halt_req = 1'b0;
      bp_valid = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      check("rst_state", 32'(state), 0);
      check("rst_cpu_en", 32'(cpu_en), 0);
      check("rst_instr", 32'(cpu_instruction), 0);
      check("rst_done", 32'(done), 0);
      check("rst_bp_hit", 32'(bp_hit), 0);
      check("rst_retired", 32'(retired), 0);
      rst_n = 1'b1;
   endtask

   int np;
   int k;

   initial begin
      #1 rst_n = 1'b0;

      // free run to end of program
      do_reset();
      run = 1'b1;
      np  = 0;
      k   = 0;
      while (!done && k < 200) begin
         @(negedge clk);
         if (cpu_en) np++;
         k++;
      end
      check("t1_done", 32'(done), 1);
      check("t1_pulses", np, 21);
      check("t1_retired", 32'(retired), 21);
      check("t1_state", 32'(state), 3);
      check("t1_pc", 32'(cpu_pc), 21);
      run = 1'b0;
      repeat (3) @(negedge clk);
      check("t1_sticky", 32'(state), 3);

      // three single steps
      do_reset();
      np = 0;
      for (int s = 0; s < 3; s++) begin
         step = 1'b1;
         repeat (5) begin
            @(negedge clk);
            if (cpu_en) np++;
         end
         check("t2_idle", 32'(state), 0);
         step = 1'b0;
         repeat (5) begin
            @(negedge clk);
            if (cpu_en) np++;
         end
      end
      check("t2_pulses", np, 3);
      check("t2_retired", 32'(retired), 3);

      // halt request during a fetch
      do_reset();
      run = 1'b1;
      k   = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(state == 2'b01 && retired == 3) && k < 50);
      check("t3_sync", 32'(retired), 3);
      halt_req = 1'b1;
      np = 0;
      repeat (4) begin
         @(negedge clk);
         if (cpu_en) np++;
      end
      check("t3_pulses", np, 1);
      check("t3_retired", 32'(retired), 4);
      check("t3_state", 32'(state), 3);
      halt_req = 1'b0;
      run      = 1'b0;
      @(negedge clk);
      check("t3_idle", 32'(state), 0);
      check("t3_ret_hold", 32'(retired), 4);

      // halt wins over run and step in idle
      do_reset();
      halt_req = 1'b1;
      run      = 1'b1;
      step     = 1'b1;
      np = 0;
      repeat (3) begin
         @(negedge clk);
         if (cpu_en) np++;
      end
      check("t4_pulses", np, 0);
      check("t4_state", 32'(state), 3);
      halt_req = 1'b0;
      run      = 1'b0;
      step     = 1'b0;
      @(negedge clk);
      check("t4_idle", 32'(state), 0);
      check("t4_retired", 32'(retired), 0);

`ifdef BREAKPOINT_EN
      // breakpoint at PC 5, then resume through it
      do_reset();
      bp_addr  = 8'h05;
      bp_valid = 1'b1;
      run      = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (state != 2'b11 && k < 100);
      check("t5_state", 32'(state), 3);
      check("t5_pc", 32'(cpu_pc), 5);
      check("t5_retired", 32'(retired), 5);
      check("t5_bp_hit", 32'(bp_hit), 1);
      check("t5_done", 32'(done), 0);
      run = 1'b0;
      @(negedge clk);
      check("t5_release", 32'(state), 0);
      check("t5_bp_clr", 32'(bp_hit), 0);
      run = 1'b1;
      k = 0;
      while (!done && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("t5_end_done", 32'(done), 1);
      check("t5_end_ret", 32'(retired), 21);
      check("t5_end_bp", 32'(bp_hit), 0);
      bp_valid = 1'b0;
`endif

      // asynchronous reset in the middle of an execute cycle
      do_reset();
      run = 1'b1;
      k   = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(cpu_en && retired == 2) && k < 50);
      check("t6_sync", 32'(cpu_en), 1);
      #1 rst_n = 1'b0;
      #1;
      check("t6_cpu_en", 32'(cpu_en), 0);
      check("t6_state", 32'(state), 0);
      check("t6_retired", 32'(retired), 0);
      check("t6_instr", 32'(cpu_instruction), 0);
      check("t6_done", 32'(done), 0);
      check("t6_bp_hit", 32'(bp_hit), 0);
      run = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
